// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding, flag bit positions and default widths of the multiply issue stage.
package mul_pkg;
    localparam int DW_DEF    = 16;
    localparam int TAG_W_DEF = 4;
    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic logic [3:0] pack_flags(input logic z, input logic n, input logic c, input logic v);
        logic [3:0] f;
        f     = '0;
        f[FZ] = z;
        f[FN] = n;
        f[FC] = c;
        f[FV] = v;
        return f;
    endfunction
endpackage

// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if: op request, multiplier and writeback signals of the multiply issue stage.
interface mul_issue_ctrl_if
    import mul_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int TAG_W = TAG_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_a;
    logic [DW-1:0]    in_b;
    logic [TAG_W-1:0] in_tag;
    logic             mul_start;
    logic [DW-1:0]    mul_a;
    logic [DW-1:0]    mul_b;
    logic [DW-1:0]    mul_lo;
    logic [DW-1:0]    mul_hi;
    logic             mul_done;
    logic             mul_z;
    logic             mul_n;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_lo;
    logic [DW-1:0]    out_hi;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;
    logic             out_err;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, mul_lo, mul_hi, mul_done, mul_z, mul_n, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_lo, out_hi, out_tag, out_flags, out_err
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, mul_lo, mul_hi, mul_done, mul_z, mul_n, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_lo, out_hi, out_tag, out_flags, out_err
    );
endinterface

// File: rtl/mul_watchdog.sv
// mul_watchdog: counts enabled cycles since the last clear and flags when TIMEOUT_CYC-1 is reached.
module mul_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt;

    assign expired = cnt == CW'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + CW'(1);
endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/collect stage around a signed DWxDW multiplier; holds operands through the run
// and returns the product with {Z,N,C,V} flags, or a zero result with out_err when the watchdog fires.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input logic             clk,
    input logic             rst,
    mul_issue_ctrl_if.slave bus
);
    state_t           state, state_n;
    logic             done_q, cap, expired, accept;
    logic [DW-1:0]    a_q, b_q, lo_q, hi_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       flags_q;
    logic             err_q;

    assign accept = (state == IDLE) && bus.in_valid;
    // only a fresh done edge counts, so a level left over from the previous op is ignored
    assign cap    = (state == WAIT) && bus.mul_done && !done_q;

    mul_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == START),
        .en      (state == WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n       = state;
        bus.in_ready  = 1'b0;
        bus.mul_start = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_n = START;
            end
            START: begin
                bus.mul_start = 1'b1;
                state_n       = WAIT;
            end
            WAIT: if (cap || expired) state_n = HOLD;
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            done_q <= bus.mul_done;
            if (accept) begin
                a_q   <= bus.in_a;
                b_q   <= bus.in_b;
                tag_q <= bus.in_tag;
            end
            // capture has priority over a timeout landing on the same cycle
            if (cap) begin
                lo_q    <= bus.mul_lo;
                hi_q    <= bus.mul_hi;
                flags_q <= pack_flags(bus.mul_z, bus.mul_n, 1'b0, bus.mul_hi != {DW{bus.mul_lo[DW-1]}});
                err_q   <= 1'b0;
            end else if (state == WAIT && expired) begin
                lo_q    <= '0;
                hi_q    <= '0;
                flags_q <= '0;
                err_q   <= 1'b1;
            end
        end

    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.out_lo    = lo_q;
    assign bus.out_hi    = hi_q;
    assign bus.out_tag   = tag_q;
    assign bus.out_flags = flags_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: table vectors, corner sequences and random ops against a behavioural multiplier stub
// and an arithmetic reference model.
module tb_mul_issue_ctrl;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;
    int   mode = 0;
    int   lat = 1;
    logic pulse = 1'b0;

    always #5 clk = ~clk;

    mul_issue_ctrl_if #(.DW(16), .TAG_W(4)) bus ();

    mul_issue_ctrl #(.DW(16), .TAG_W(4), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // multiplier stand-in: mode 0 normal, 1 done stuck high, 2 done never asserted
    logic               mrst_n;
    int                 m_cnt;
    logic               m_done, m_z, m_n;
    logic [15:0]        m_lo, m_hi;
    logic signed [31:0] m_p;

    assign mrst_n = ~rst;
    assign m_p    = $signed(bus.mul_a) * $signed(bus.mul_b);

    always @(posedge clk or negedge mrst_n)
        if (!mrst_n) begin
            m_cnt <= 0; m_done <= 1'b0; m_lo <= '0; m_hi <= '0; m_z <= 1'b0; m_n <= 1'b0;
        end else if (bus.mul_start) begin
            m_cnt <= lat; m_done <= 1'b0;
        end else if (m_cnt == 1) begin
            m_cnt <= 0; m_done <= 1'b1; m_lo <= m_p[15:0]; m_hi <= m_p[31:16];
            m_z <= m_p == 0; m_n <= m_p[31];
        end else begin
            if (m_cnt > 1) m_cnt <= m_cnt - 1;
            if (pulse) m_done <= 1'b0;
        end

    assign bus.mul_done = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : m_done;
    assign bus.mul_lo   = m_lo;
    assign bus.mul_hi   = m_hi;
    assign bus.mul_z    = m_z;
    assign bus.mul_n    = m_n;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        int          lat;
        logic        pulse;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [3:0]  fl;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] lo, output logic [15:0] hi, output logic [3:0] fl);
        longint      p;
        logic [31:0] u;
        p  = longint'($signed(a)) * longint'($signed(b));
        u  = p[31:0];
        lo = u[15:0];
        hi = u[31:16];
        fl = {p == 0, p < 0, 1'b0, (p > 32767 || p < -32768)};
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag, input string nm);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "/in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_a = 16'($urandom); bus.in_b = 16'($urandom); bus.in_tag = 4'($urandom);
        chk({nm, "/start"}, 64'(bus.mul_start), 64'd1);
        @(negedge clk);
        chk({nm, "/start_pulse"}, 64'(bus.mul_start), 64'd0);
    endtask

    task automatic wait_valid(input string nm, output int n, output int t_done);
        logic pd;
        pd = 1'b1;
        n = 0;
        t_done = -1;
        while (!bus.out_valid && n < TO + 20) begin
            if (t_done < 0 && bus.mul_done && !pd) t_done = n;
            pd = bus.mul_done;
            @(negedge clk);
            n++;
        end
        chk({nm, "/out_valid"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic finish_op(input string nm, input logic [15:0] e_lo, input logic [15:0] e_hi,
                             input logic [3:0] e_fl, input logic e_err, input logic [3:0] e_tag,
                             input int stall, input logic poke);
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                bus.in_valid = 1'b1; bus.in_a = 16'($urandom); bus.in_b = 16'($urandom);
            end
            chk($sformatf("%s/hold%0d", nm, s),
                {bus.out_valid, bus.in_ready, bus.mul_start, bus.out_lo, bus.out_hi, bus.out_flags, bus.out_err, bus.out_tag},
                {1'b1, 1'b0, 1'b0, e_lo, e_hi, e_fl, e_err, e_tag});
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk({nm, "/lo"}, 64'(bus.out_lo), 64'(e_lo));
        chk({nm, "/hi"}, 64'(bus.out_hi), 64'(e_hi));
        chk({nm, "/flags"}, 64'(bus.out_flags), 64'(e_fl));
        chk({nm, "/err"}, 64'(bus.out_err), 64'(e_err));
        chk({nm, "/tag"}, 64'(bus.out_tag), 64'(e_tag));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({nm, "/drain"}, {bus.out_valid, bus.in_ready, bus.mul_start}, 64'b010);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                         input int stall, input logic poke, input string nm,
                         input logic [15:0] e_lo, input logic [15:0] e_hi, input logic [3:0] e_fl, input logic e_err);
        int n, td;
        issue(a, b, tag, nm);
        wait_valid(nm, n, td);
        if (e_err) chk({nm, "/timeout_cyc"}, 64'(n), 64'(TO));
        else chk({nm, "/latency"}, 64'(n), 64'(td + 1));
        finish_op(nm, e_lo, e_hi, e_fl, e_err, tag, stall, poke);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        logic [15:0] a, b, lo, hi;
        logic [3:0]  fl;
        logic        leftover;
        int          n, td;

        vt[0] = '{16'h0003, 16'hFFFC, 4'h1, 1, 1'b0, 16'hFFF4, 16'hFFFF, 4'b0100};
        vt[1] = '{16'h0100, 16'h0100, 4'h2, 2, 1'b1, 16'h0000, 16'h0001, 4'b0001};
        vt[2] = '{16'h0000, 16'h7FFF, 4'h3, 3, 1'b0, 16'h0000, 16'h0000, 4'b1000};
        vt[3] = '{16'hFFFF, 16'hFFFF, 4'h4, 1, 1'b1, 16'h0001, 16'h0000, 4'b0000};
        vt[4] = '{16'h0005, 16'h0007, 4'h5, 4, 1'b0, 16'h0023, 16'h0000, 4'b0000};
        vt[5] = '{16'h7FFF, 16'h7FFF, 4'h6, 2, 1'b0, 16'h0001, 16'h3FFF, 4'b0001};
        vt[6] = '{16'h8000, 16'h8000, 4'h7, 5, 1'b1, 16'h0000, 16'h4000, 4'b0001};
        vt[7] = '{16'h8000, 16'h0001, 4'h8, 1, 1'b0, 16'h8000, 16'hFFFF, 4'b0100};
        vt[8] = '{16'h0100, 16'h0080, 4'h9, 3, 1'b0, 16'h8000, 16'h0000, 4'b0001};
        vt[9] = '{16'hFF00, 16'h0080, 4'hA, 2, 1'b1, 16'h8000, 16'hFFFF, 4'b0100};

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst/out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst/mul_start", 64'(bus.mul_start), 64'd0);
        chk("rst/operands", {bus.mul_a, bus.mul_b}, 64'd0);
        chk("rst/result", {bus.out_lo, bus.out_hi, bus.out_tag, bus.out_flags, bus.out_err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            lat = vt[i].lat;
            pulse = vt[i].pulse;
            do_op(vt[i].a, vt[i].b, vt[i].tag, 0, 1'b0, $sformatf("vec%0d", i), vt[i].lo, vt[i].hi, vt[i].fl, 1'b0);
        end

        lat = 2; pulse = 1'b0;
        do_op(16'h1234, 16'h0002, 4'hB, 10, 1'b1, "backpressure", 16'h2468, 16'h0000, 4'b0000, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 4'hC, 0, 1'b0, "bp_next", 16'h0001, 16'h0000, 4'b0000, 1'b0);

        mode = 1;
        do_op(16'h0007, 16'h0009, 4'hD, 1, 1'b0, "stale_done", 16'h0000, 16'h0000, 4'b0000, 1'b1);
        mode = 2;
        do_op(16'h0011, 16'h0013, 4'hE, 0, 1'b0, "no_done", 16'h0000, 16'h0000, 4'b0000, 1'b1);
        mode = 0;

        lat = 30;
        issue(16'h0009, 16'h0009, 4'h3, "rst_wait");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait/out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_wait/in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_wait/operands", {bus.mul_a, bus.mul_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        leftover = 1'b0;
        repeat (40) begin
            @(negedge clk);
            leftover |= bus.out_valid;
        end
        chk("rst_wait/leftover", 64'(leftover), 64'd0);
        lat = 3;
        do_op(16'h0005, 16'h0007, 4'h6, 0, 1'b0, "after_rst", 16'h0023, 16'h0000, 4'b0000, 1'b0);

        lat = 1;
        issue(16'h0003, 16'h0003, 4'h7, "rst_hold");
        wait_valid("rst_hold", n, td);
        #2 rst = 1'b1;
        #1;
        chk("rst_hold/out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_hold/in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_hold/result", {bus.out_lo, bus.out_hi, bus.out_flags, bus.out_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'(($urandom_range(0, 4) == 0) ? 0 : ($urandom_range(0, 1) ? 16'h8000 : 16'h7FFF)) : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1) ? 16'hFFFF : 16'h0001) : 16'($urandom);
            lat = $urandom_range(1, 6);
            pulse = 1'($urandom_range(0, 1));
            ref_mul(a, b, lo, hi, fl);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(a, b, 4'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), lo, hi, fl, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
